// File: rtl/spi_byte_if.sv
// ---------------------------------------------------------------------------
// spi_byte_if
//
// SPI-slave byte front end (mode 0, MSB first). The external SPI bus is
// oversampled on sys_clk. Each complete received byte is presented on
// data_in with a one-cycle data_rdy strobe. The byte that the core loads via
// data_out/data_latch is shifted back out on spi_miso.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   spi_sclk     in   SPI clock (asynchronous to sys_clk)
//   spi_cs_n     in   SPI chip select, active low
//   spi_mosi     in   SPI serial data in
//   spi_miso     out  SPI serial data out, 0 when not shifting
//   data_in      out  last complete received byte
//   data_rdy     out  one-cycle pulse when data_in updates
//   data_out     in   byte to transmit
//   data_latch   in   one-cycle request to capture data_out
//   frame_active out  high while a frame is in progress
//   byte_idx     out  bytes completed in this frame, saturates at 3
//   tx_underrun  out  one-cycle pulse when a tx load finds nothing to send
// ---------------------------------------------------------------------------
module spi_byte_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] data_in,
  output logic       data_rdy,
  input  logic [7:0] data_out,
  input  logic       data_latch,
  output logic       frame_active,
  output logic [1:0] byte_idx,
  output logic       tx_underrun
);

  typedef enum logic [1:0] {
    WAIT_DESEL = 2'd0,
    IDLE       = 2'd1,
    SHIFT      = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Input synchronisers
  // -------------------------------------------------------------------------
  // cs_n chain resets to 0 (selected): a deselect is only believed once the
  // real pin has been seen high, so a master that keeps cs_n low across a
  // reset cannot fake a cs_n falling edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_s, cs_s, mosi_s;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Edge detection. Edges are registered so the FSM works from flop outputs;
  // mosi is delayed by the same stage so it lines up with sclk_rise_q.
  // -------------------------------------------------------------------------
  logic sclk_prev_q, sclk_prev_d;
  logic cs_prev_q,   cs_prev_d;
  logic sclk_rise_q, sclk_rise_d;
  logic sclk_fall_q, sclk_fall_d;
  logic cs_rise_q,   cs_rise_d;
  logic cs_fall_q,   cs_fall_d;
  logic mosi_dly_q,  mosi_dly_d;

  always_comb begin
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    sclk_rise_d =  sclk_s & ~sclk_prev_q;
    sclk_fall_d = ~sclk_s &  sclk_prev_q;
    cs_rise_d   =  cs_s   & ~cs_prev_q;
    cs_fall_d   = ~cs_s   &  cs_prev_q;
    mosi_dly_d  = mosi_s;
  end

  // -------------------------------------------------------------------------
  // Frame FSM, shift registers and TX holding register
  // -------------------------------------------------------------------------
  state_e     state_q,        state_d;
  logic [2:0] bit_cnt_q,      bit_cnt_d;
  logic [7:0] rx_sr_q,        rx_sr_d;
  logic [7:0] tx_sr_q,        tx_sr_d;
  logic [7:0] hold_q,         hold_d;
  logic       hold_vld_q,     hold_vld_d;
  logic [7:0] data_in_q,      data_in_d;
  logic       data_rdy_q,     data_rdy_d;
  logic       frame_active_q, frame_active_d;
  logic [1:0] byte_idx_q,     byte_idx_d;
  logic       underrun_q,     underrun_d;
  logic       load;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    data_in_d      = data_in_q;
    data_rdy_d     = 1'b0;
    frame_active_d = frame_active_q;
    byte_idx_d     = byte_idx_q;
    underrun_d     = 1'b0;
    load           = 1'b0;

    case (state_q)
      WAIT_DESEL: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall_q) begin
          state_d        = SHIFT;
          frame_active_d = 1'b1;
          bit_cnt_d      = 3'd0;
          byte_idx_d     = 2'd0;
          load           = 1'b1;
        end
      end
      SHIFT: begin
        // Deselect has priority over a coincident sclk edge; a partial byte
        // is simply dropped because bit_cnt restarts on the next frame.
        if (cs_rise_q) begin
          state_d        = IDLE;
          frame_active_d = 1'b0;
        end else if (sclk_rise_q) begin
          rx_sr_d   = {rx_sr_q[6:0], mosi_dly_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_in_d  = {rx_sr_q[6:0], mosi_dly_q};
            data_rdy_d = 1'b1;
            if (byte_idx_q != 2'd3) byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (sclk_fall_q) begin
          if (bit_cnt_q != 3'd0) tx_sr_d = {tx_sr_q[6:0], 1'b0};
          else                   load    = 1'b1;  // byte boundary
        end
      end
      default: state_d = WAIT_DESEL;
    endcase

    // TX source selection. A latch landing in the load cycle itself bypasses
    // the holding register so the freshest byte goes straight out.
    if (load) begin
      if (data_latch) begin
        tx_sr_d    = data_out;
        hold_vld_d = 1'b0;
      end else if (hold_vld_q) begin
        tx_sr_d    = hold_q;
        hold_vld_d = 1'b0;
      end else begin
        tx_sr_d    = 8'h00;
        underrun_d = 1'b1;
      end
    end else if (data_latch && (state_q != WAIT_DESEL)) begin
      hold_d     = data_out;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q    <= '0;
      cs_sync_q      <= '0;
      mosi_sync_q    <= '0;
      sclk_prev_q    <= 1'b0;
      cs_prev_q      <= 1'b0;
      sclk_rise_q    <= 1'b0;
      sclk_fall_q    <= 1'b0;
      cs_rise_q      <= 1'b0;
      cs_fall_q      <= 1'b0;
      mosi_dly_q     <= 1'b0;
      state_q        <= WAIT_DESEL;
      bit_cnt_q      <= 3'd0;
      rx_sr_q        <= 8'h00;
      tx_sr_q        <= 8'h00;
      hold_q         <= 8'h00;
      hold_vld_q     <= 1'b0;
      data_in_q      <= 8'h00;
      data_rdy_q     <= 1'b0;
      frame_active_q <= 1'b0;
      byte_idx_q     <= 2'd0;
      underrun_q     <= 1'b0;
    end else begin
      sclk_sync_q    <= sclk_sync_d;
      cs_sync_q      <= cs_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      sclk_prev_q    <= sclk_prev_d;
      cs_prev_q      <= cs_prev_d;
      sclk_rise_q    <= sclk_rise_d;
      sclk_fall_q    <= sclk_fall_d;
      cs_rise_q      <= cs_rise_d;
      cs_fall_q      <= cs_fall_d;
      mosi_dly_q     <= mosi_dly_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_sr_q        <= rx_sr_d;
      tx_sr_q        <= tx_sr_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      data_in_q      <= data_in_d;
      data_rdy_q     <= data_rdy_d;
      frame_active_q <= frame_active_d;
      byte_idx_q     <= byte_idx_d;
      underrun_q     <= underrun_d;
    end
  end

  assign spi_miso     = (state_q == SHIFT) ? tx_sr_q[7] : 1'b0;
  assign data_in      = data_in_q;
  assign data_rdy     = data_rdy_q;
  assign frame_active = frame_active_q;
  assign byte_idx     = byte_idx_q;
  assign tx_underrun  = underrun_q;

endmodule

// File: tb/tb_spi_byte_if.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_if: directed self-checking bench for spi_byte_if. A bench-side
// SPI master drives mode-0 frames; a monitor logs every data_rdy pulse along
// with data_in, byte_idx and the running tx_underrun count.
// ---------------------------------------------------------------------------
module tb_spi_byte_if;
  localparam int S    = 2;
  localparam int HALF = 8;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] data_in;
  logic       data_rdy;
  logic [7:0] data_out = 8'h00;
  logic       data_latch = 1'b0;
  logic       frame_active;
  logic [1:0] byte_idx;
  logic       tx_underrun;

  spi_byte_if #(.SYNC_STAGES(S)) dut (
    .sys_clk(sys_clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .data_in(data_in),
    .data_rdy(data_rdy), .data_out(data_out), .data_latch(data_latch),
    .frame_active(frame_active), .byte_idx(byte_idx), .tx_underrun(tx_underrun)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [7:0] d; logic [1:0] idx; int ur; } rdy_t;
  rdy_t rdy_q[$];
  int   ur_cnt = 0;

  always @(negedge sys_clk) begin
    if (data_rdy) rdy_q.push_back('{d: data_in, idx: byte_idx, ur: ur_cnt});
    if (tx_underrun) ur_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Shift the top n bits of b; returns MISO as sampled just before each rise.
  task automatic spi_bits(input int n, input logic [7:0] b, output logic [7:0] miso);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      tick(HALF);
      m = {m[6:0], spi_miso};
      spi_sclk = 1'b1;
      tick(HALF);
      spi_sclk = 1'b0;
    end
    miso = m;
  endtask

  task automatic latch(input logic [7:0] v);
    data_out = v;
    data_latch = 1'b1;
    tick(1);
    data_latch = 1'b0;
  endtask

  task automatic start_frame();
    rdy_q.delete();
    ur_cnt = 0;
    spi_cs_n = 1'b0;
  endtask

  task automatic end_frame();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(HALF);
  endtask

  typedef struct {
    logic [7:0] mosi;
    bit         pre_latch;
    logic [7:0] latch_val;
    logic [7:0] exp_data_in;
    logic [7:0] exp_miso;
    int         exp_ur;
  } vec_t;

  vec_t tbl[5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] m, m0, m1, m2;
    logic [1:0] exp_idx [5];

    tbl[0] = '{8'h85, 1'b0, 8'h00, 8'h85, 8'h00, 1};
    tbl[1] = '{8'hFF, 1'b1, 8'h3C, 8'hFF, 8'h3C, 0};
    tbl[2] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    tbl[3] = '{8'h5A, 1'b1, 8'h01, 8'h5A, 8'h01, 0};
    tbl[4] = '{8'hA5, 1'b0, 8'h00, 8'hA5, 8'h00, 1};
    exp_idx = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset state
    tick(3);
    check("rst_miso", spi_miso, 0);
    check("rst_data_in", data_in, 8'h00);
    check("rst_data_rdy", data_rdy, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_byte_idx", byte_idx, 0);
    check("rst_underrun", tx_underrun, 0);
    rst = 1'b0;
    tick(HALF);

    // Single-byte frames
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].pre_latch) latch(tbl[i].latch_val);
      start_frame();
      spi_bits(8, tbl[i].mosi, m);
      check($sformatf("v%0d_frame_active", i), frame_active, 1);
      check($sformatf("v%0d_miso_byte", i), m, tbl[i].exp_miso);
      end_frame();
      check($sformatf("v%0d_rdy_count", i), rdy_q.size(), 1);
      if (rdy_q.size() == 1) begin
        check($sformatf("v%0d_data_in", i), rdy_q[0].d, tbl[i].exp_data_in);
        check($sformatf("v%0d_byte_idx", i), rdy_q[0].idx, 1);
        check($sformatf("v%0d_underruns", i), rdy_q[0].ur, tbl[i].exp_ur);
      end
      check($sformatf("v%0d_miso_desel", i), spi_miso, 0);
      check($sformatf("v%0d_frame_inactive", i), frame_active, 0);
    end

    // Three-byte frame: hold-register load, core load, then underrun
    latch(8'hA5);
    start_frame();
    spi_bits(8, 8'h81, m0);
    latch(8'h5A);
    spi_bits(8, 8'h12, m1);
    spi_bits(8, 8'h34, m2);
    check("tx3_miso0", m0, 8'hA5);
    check("tx3_miso1", m1, 8'h5A);
    check("tx3_miso2", m2, 8'h00);
    check("tx3_rdy_count", rdy_q.size(), 3);
    if (rdy_q.size() == 3) begin
      check("tx3_data0", rdy_q[0].d, 8'h81);
      check("tx3_data1", rdy_q[1].d, 8'h12);
      check("tx3_data2", rdy_q[2].d, 8'h34);
      check("tx3_ur_before_third_load", rdy_q[1].ur, 0);
      check("tx3_ur_after_third_load", rdy_q[2].ur, 1);
    end
    end_frame();

    // Partial byte discarded on deselect
    start_frame();
    spi_bits(5, 8'hFF, m);
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(HALF);
    check("part_rdy_count", rdy_q.size(), 0);
    check("part_frame_active", frame_active, 0);
    check("part_data_in_held", data_in, 8'h34);
    check("part_miso", spi_miso, 0);
    start_frame();
    spi_bits(8, 8'h3C, m);
    end_frame();
    check("part_next_rdy_count", rdy_q.size(), 1);
    check("part_next_data_in", data_in, 8'h3C);

    // Reset mid-byte with cs_n low and sclk running
    start_frame();
    spi_bits(3, 8'hFF, m);
    spi_sclk = 1'b1;
    tick(2);
    #1 rst = 1'b1;
    #1;
    check("mrst_miso", spi_miso, 0);
    check("mrst_data_in", data_in, 8'h00);
    check("mrst_data_rdy", data_rdy, 0);
    check("mrst_frame_active", frame_active, 0);
    check("mrst_byte_idx", byte_idx, 0);
    check("mrst_underrun", tx_underrun, 0);
    tick(1);
    rst = 1'b0;
    rdy_q.delete();
    tick(HALF);
    spi_sclk = 1'b0;
    spi_bits(8, 8'hFF, m);
    spi_bits(8, 8'h55, m);
    check("mrst_no_rdy_while_cs_low", rdy_q.size(), 0);
    check("mrst_no_frame_while_cs_low", frame_active, 0);
    end_frame();
    check("mrst_no_rdy_after_desel", rdy_q.size(), 0);
    start_frame();
    spi_bits(8, 8'hC3, m);
    end_frame();
    check("mrst_next_rdy_count", rdy_q.size(), 1);
    check("mrst_next_data_in", data_in, 8'hC3);

    // data_latch coinciding with a byte-boundary load, hold empty
    start_frame();
    spi_bits(8, 8'h11, m0);
    tick(S + 1);
    data_out = 8'h77;
    data_latch = 1'b1;
    tick(1);
    data_latch = 1'b0;
    spi_bits(8, 8'h22, m1);
    check("bypass_miso0", m0, 8'h00);
    check("bypass_miso1", m1, 8'h77);
    check("bypass_rdy_count", rdy_q.size(), 2);
    if (rdy_q.size() == 2) begin
      check("bypass_ur_start", rdy_q[0].ur, 1);
      check("bypass_ur_boundary", rdy_q[1].ur, 1);
    end
    end_frame();

    // byte_idx saturation over a five-byte frame
    start_frame();
    for (int i = 0; i < 5; i++) spi_bits(8, 8'(i + 1), m);
    end_frame();
    check("sat_rdy_count", rdy_q.size(), 5);
    if (rdy_q.size() == 5)
      for (int i = 0; i < 5; i++) check($sformatf("sat_idx%0d", i), rdy_q[i].idx, exp_idx[i]);
    check("sat_idx_held_idle", byte_idx, 3);
    start_frame();
    tick(HALF);
    check("sat_idx_cleared", byte_idx, 0);
    check("sat_frame_active", frame_active, 1);
    spi_bits(8, 8'h99, m);
    end_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
